// File: rtl/f1_reaction_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : f1_reaction_timer_if
// Description : Control and result bundle between the start-light / reaction
//               timer and its surroundings (ms tick source, buttons, LEDR
//               bank and BCD display chain).
// Revision    : 1.0 - initial release
// ============================================================================
interface f1_reaction_timer_if #(
    parameter int N_LIGHTS = 5,
    parameter int CNT_W    = 14
);
    logic                tick_ms;
    logic                trigger;
    logic                react;
    logic [N_LIGHTS-1:0] lights;
    logic [CNT_W-1:0]    time_ms;
    logic                valid;
    logic                false_start;
    logic                timeout;
    logic [CNT_W-1:0]    best_ms;
    logic                busy;

    // Environment side: drives the tick and the two buttons, observes results
    modport master (
        output tick_ms, trigger, react,
        input  lights, time_ms, valid, false_start, timeout, best_ms, busy
    );

    // Timer side
    modport slave (
        input  tick_ms, trigger, react,
        output lights, time_ms, valid, false_start, timeout, best_ms, busy
    );
endinterface
`default_nettype wire

// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module      : f1_reaction_timer
// Description : F1 start-light sequencer with LFSR-randomised hold, reaction
//               counter, false-start detection, timeout saturation and a
//               best-time register. Counting is qualified by a 1 ms tick.
// Revision    : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int N_LIGHTS     = 5,
    parameter int STEP_MS      = 500,
    parameter int DELAY_MIN_MS = 200,
    parameter int DELAY_SCALE  = 8,
    parameter int LFSR_W       = 7,
    parameter int CNT_W        = 14,
    parameter int MAX_MS       = 9999
) (
    input  wire                   clk,
    input  wire                   rst,
    f1_reaction_timer_if.slave    bus
);

    // Maximal-length feedback masks (Fibonacci, shift towards MSB)
    function automatic logic [7:0] f_taps(input int w);
        case (w)
            4:       f_taps = 8'h0C;  // x^4 + x^3 + 1
            5:       f_taps = 8'h14;  // x^5 + x^3 + 1
            6:       f_taps = 8'h30;  // x^6 + x^5 + 1
            7:       f_taps = 8'h60;  // x^7 + x^6 + 1
            default: f_taps = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
        endcase
    endfunction

    localparam logic [LFSR_W-1:0] c_TAPS = LFSR_W'(f_taps(LFSR_W));

    // One shared step/hold counter, sized for the longer of the two intervals
    localparam int c_HOLD_MAX = DELAY_MIN_MS + ((1 << LFSR_W) - 1) * DELAY_SCALE;
    localparam int c_CTR_MAX  = (c_HOLD_MAX > STEP_MS) ? c_HOLD_MAX : STEP_MS;
    localparam int c_CTR_W    = $clog2(c_CTR_MAX + 1);

    localparam logic [c_CTR_W-1:0]  c_STEP_LAST = c_CTR_W'(STEP_MS - 1);
    localparam logic [CNT_W-1:0]    c_MAX       = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0]    c_MAX_M1    = CNT_W'(MAX_MS - 1);
    localparam logic [N_LIGHTS-1:0] c_ALL_ON    = '1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LIGHTS = 3'd1;
    localparam logic [2:0] c_HOLD   = 3'd2;
    localparam logic [2:0] c_TIMING = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_FAULT  = 3'd5;

    logic [2:0]          r_state;
    logic                r_trig_q;
    logic                r_react_q;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [c_CTR_W-1:0]  r_step;
    logic [c_CTR_W-1:0]  r_hold;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_LIGHTS-1:0] r_lights;
    logic [CNT_W-1:0]    r_time;
    logic                r_valid;
    logic                r_false_start;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_best;
    logic                r_busy;

    logic                w_trig_edge;
    logic                w_react_edge;
    logic [LFSR_W-1:0]   w_lfsr_next;
    logic [c_CTR_W-1:0]  w_hold_calc;
    logic [c_CTR_W-1:0]  w_ctr_inc;
    logic                w_hold_done;

    assign w_trig_edge  = bus.trigger & ~r_trig_q;
    assign w_react_edge = bus.react & ~r_react_q;
    assign w_lfsr_next  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & c_TAPS)};
    assign w_hold_calc  = c_CTR_W'(DELAY_MIN_MS) + c_CTR_W'(r_lfsr) * c_CTR_W'(DELAY_SCALE);
    assign w_ctr_inc    = r_step + c_CTR_W'(1);
    // ">=" rather than "==" so a zero-length hold still leaves on the first tick
    assign w_hold_done  = (w_ctr_inc >= r_hold);

    // Sequencer: edge capture, free-running LFSR and the run state machine
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_trig_q      <= 1'b0;
            r_react_q     <= 1'b0;
            r_lfsr        <= LFSR_W'(1);
            r_step        <= '0;
            r_hold        <= '0;
            r_cnt         <= '0;
            r_lights      <= '0;
            r_time        <= '0;
            r_valid       <= 1'b0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
            r_best        <= c_MAX;
            r_busy        <= 1'b0;
        end else begin
            r_trig_q  <= bus.trigger;
            r_react_q <= bus.react;
            r_lfsr    <= w_lfsr_next;

            case (r_state)
                c_IDLE, c_DONE, c_FAULT: begin
                    // time_ms is intentionally kept until a new result lands
                    if (w_trig_edge) begin
                        r_state       <= c_LIGHTS;
                        r_busy        <= 1'b1;
                        r_lights      <= '0;
                        r_step        <= '0;
                        r_valid       <= 1'b0;
                        r_false_start <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end

                c_LIGHTS: begin
                    if (w_react_edge) begin
                        r_state       <= c_FAULT;
                        r_busy        <= 1'b0;
                        r_false_start <= 1'b1;
                        r_lights      <= c_ALL_ON;
                    end else if (bus.tick_ms) begin
                        if (r_step == c_STEP_LAST) begin
                            r_step <= '0;
                            // Last light already on: this interval was the
                            // extra one before the random hold
                            if (r_lights[N_LIGHTS-1]) begin
                                r_state <= c_HOLD;
                                r_hold  <= w_hold_calc;
                            end else begin
                                r_lights <= (r_lights << 1) | N_LIGHTS'(1);
                            end
                        end else begin
                            r_step <= w_ctr_inc;
                        end
                    end
                end

                c_HOLD: begin
                    if (w_react_edge) begin
                        r_state       <= c_FAULT;
                        r_busy        <= 1'b0;
                        r_false_start <= 1'b1;
                        r_lights      <= c_ALL_ON;
                    end else if (bus.tick_ms) begin
                        if (w_hold_done) begin
                            r_state  <= c_TIMING;
                            r_lights <= '0;
                            r_cnt    <= '0;
                            r_step   <= '0;
                        end else begin
                            r_step <= w_ctr_inc;
                        end
                    end
                end

                c_TIMING: begin
                    // React has priority so a coincident tick yields the
                    // pre-increment count
                    if (w_react_edge) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_time  <= r_cnt;
                        r_valid <= 1'b1;
                        if (r_cnt < r_best) begin
                            r_best <= r_cnt;
                        end
                    end else if (bus.tick_ms) begin
                        if (r_cnt == c_MAX_M1) begin
                            r_state   <= c_DONE;
                            r_busy    <= 1'b0;
                            r_cnt     <= c_MAX;
                            r_time    <= c_MAX;
                            r_timeout <= 1'b1;
                            r_valid   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lights      = r_lights;
    assign bus.time_ms     = r_time;
    assign bus.valid       = r_valid;
    assign bus.false_start = r_false_start;
    assign bus.timeout     = r_timeout;
    assign bus.best_ms     = r_best;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
Parametrised F1 start-light and reaction-time controller. It merges light sequencing, the random hold delay and the reaction counter into one block running on the system clock with a 1 ms enable. It adds configurable light count, an internal LFSR for the random hold, false-start detection, timeout saturation and a best-time register. Its outputs drive the LEDR bank and the BCD/7-segment display chain.

Parameters:
N_LIGHTS, 5, number of start lights (1..10)
STEP_MS, 500, ms between successive lights, and from the last light to the start of the hold
DELAY_MIN_MS, 200, minimum random hold after all lights are on
DELAY_SCALE, 8, ms per LFSR LSB added to the hold
LFSR_W, 7, LFSR width (4..8), maximal-length taps from a fixed table
CNT_W, 14, width of the reaction counter and the best-time register
MAX_MS, 9999, timeout and saturation value (must be < 2^CNT_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
tick_ms  in  1  one-cycle enable, once per ms
trigger  in  1  start request, level; rising edge used
react  in  1  driver button, level, pre-synchronised; rising edge used
lights  out  N_LIGHTS  start-light drive; bit 0 lights first
time_ms  out  CNT_W  last reaction time in ms
valid  out  1  time_ms holds a completed measurement
false_start  out  1  react edge occurred before lights out
timeout  out  1  no react edge before MAX_MS
best_ms  out  CNT_W  smallest valid time since reset
busy  out  1  high in LIGHTS, HOLD and TIMING

Behaviour:
- Reset (rst=0 at a clk edge) values:
  - lights=0, time_ms=0, valid=0, false_start=0, timeout=0, busy=0
  - best_ms=MAX_MS
  - state=IDLE
  - LFSR=1
  - edge registers=0
- Reset mid-run aborts immediately to the values above.
- Edge detect: a registered copy of trigger and of react is updated every clk cycle. edge = input & ~registered copy. A level held high produces exactly one edge.
- LFSR: advances every clk cycle, not only on ticks. It never reaches 0.
- States:
  - IDLE / DONE / FAULT: a trigger edge goes to LIGHTS. On that transition: lights=0, step counter=0, valid=0, false_start=0, timeout=0. time_ms keeps its old value until it is overwritten.
  - LIGHTS:
    - The step counter increments on tick_ms.
    - On the tick where it reaches STEP_MS-1, it clears and the next light turns on (lights = lights<<1 | 1).
    - After the tick that lights bit N_LIGHTS-1, one further STEP_MS interval elapses, then HOLD is entered.
    - On HOLD entry the LFSR is sampled: hold = DELAY_MIN_MS + sample*DELAY_SCALE.
  - HOLD:
    - The counter counts ticks.
    - On the tick where it reaches hold-1: lights=0, reaction counter=0, go to TIMING.
  - TIMING:
    - The reaction counter increments on each tick_ms.
    - On a react edge in a cycle with no tick: time_ms = counter, valid=1, go to DONE.
    - On a react edge in the same cycle as a tick: the captured value is the pre-increment count.
    - If the counter reaches MAX_MS with no edge: time_ms=MAX_MS, timeout=1, valid=0, go to DONE.
- False start: a react edge in LIGHTS or HOLD goes to FAULT with false_start=1, lights forced all-on, and time_ms unchanged.
- best_ms: updated on the DONE entry cycle only when valid is set and time_ms < best_ms; equal values leave it unchanged. It is never updated by a timeout or a false start.
- Trigger edges in LIGHTS, HOLD or TIMING are ignored.
- A react edge in IDLE, DONE or FAULT is ignored.
- busy = state is LIGHTS, HOLD or TIMING.
- All outputs are registered. State changes take effect on the clk edge after the qualifying cycle.

Test Plan:
(All scenarios use N_LIGHTS=5, STEP_MS=4, DELAY_MIN_MS=3, DELAY_SCALE=1, LFSR_W=4, MAX_MS=50, tick_ms every 2 clk.)
1. Reset then trigger edge -> lights steps 00001, 00011 … 11111, one step per 4 ticks; HOLD lasts 3+sample ticks; then lights=0 and busy=1.
2. React edge after 17 ticks in TIMING -> time_ms=17, valid=1, best_ms=17. A second run reacting at 9 -> best_ms=9. A third run at 12 -> best_ms stays 9.
3. React edge during LIGHTS (after 2 lights) -> false_start=1, lights=11111, valid=0, time_ms and best_ms unchanged. A subsequent trigger edge clears false_start.
4. No react edge in TIMING -> after 50 ticks time_ms=50, timeout=1, valid=0, best_ms unchanged.
5. react held high through an entire run, and a trigger pulse during HOLD -> no false start from the held level and no restart; a react edge at tick 0 in the same cycle as a tick gives time_ms=0.
6. rst=0 during TIMING -> next cycle all outputs at reset values, best_ms=50, state IDLE. LFSR observed over 15 cycles hits every nonzero value exactly once.
